// File: rtl/pipe_collision_scorer_pkg.sv
// Shared Flappy-VGA game-state encodings and the boundary-hit marker.
package pkg_flappy;

  typedef enum logic [2:0] {
    ST_INITIAL = 3'b001,
    ST_PLAY    = 3'b010,
    ST_LOSE    = 3'b100
  } state_t;

  localparam logic [2:0] HIT_BOUNDARY = 3'd7;

endpackage

// File: rtl/pipe_collision_scorer_pipe_channel_check.sv
// One pipe channel: combinational bird/pipe overlap test plus the sticky
// "already scored" flag that re-arms once the pipe is recycled.
module pipe_channel_check #(
  parameter int COORD_W = 10
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               update,
  input  logic               clear,
  input  logic               pipe_valid,
  input  logic [COORD_W-1:0] bird_x_l,
  input  logic [COORD_W-1:0] bird_x_r,
  input  logic [COORD_W-1:0] bird_y_t,
  input  logic [COORD_W-1:0] bird_y_b,
  input  logic [COORD_W-1:0] pipe_x_l,
  input  logic [COORD_W-1:0] pipe_x_r,
  input  logic [COORD_W-1:0] gap_y_t,
  input  logic [COORD_W-1:0] gap_y_b,
  output logic               collide_i,
  output logic               newpass_i
);

  logic passed_reg;
  logic behind_bird;

  assign behind_bird = pipe_x_r < bird_x_l;

  assign collide_i = pipe_valid
                  && (bird_x_r >= pipe_x_l)
                  && (bird_x_l <= pipe_x_r)
                  && ((bird_y_t < gap_y_t) || (bird_y_b > gap_y_b));

  assign newpass_i = pipe_valid && behind_bird && !passed_reg;

  // A pipe that leaves the screen or reappears ahead of the bird scores again.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      passed_reg <= 1'b0;
    end else if (clear) begin
      passed_reg <= 1'b0;
    end else if (update) begin
      if (!pipe_valid || !behind_bird)
        passed_reg <= 1'b0;
      else if (newpass_i)
        passed_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_collision_scorer.sv
// Flappy-VGA game controller: per-frame collision/pass checks, the
// Initial/Play/Lose state machine, saturating score and high score.
module pipe_collision_scorer
  import pkg_flappy::*;
#(
  parameter int NUM_PIPES = 4,
  parameter int COORD_W   = 10,
  parameter int SCORE_W   = 8,
  parameter int CEIL_Y    = 0,
  parameter int FLOOR_Y   = 470
) (
  input  logic                         Clk,
  input  logic                         reset,
  input  logic                         Start,
  input  logic                         Ack,
  input  logic                         Frame_Tick,
  input  logic [COORD_W-1:0]           Bird_X_L,
  input  logic [COORD_W-1:0]           Bird_X_R,
  input  logic [COORD_W-1:0]           Bird_Y_T,
  input  logic [COORD_W-1:0]           Bird_Y_B,
  input  logic [NUM_PIPES-1:0]         Pipe_Valid,
  input  logic [NUM_PIPES*COORD_W-1:0] Pipe_X_L,
  input  logic [NUM_PIPES*COORD_W-1:0] Pipe_X_R,
  input  logic [NUM_PIPES*COORD_W-1:0] Gap_Y_T,
  input  logic [NUM_PIPES*COORD_W-1:0] Gap_Y_B,
  output logic                         Q_Initial,
  output logic                         Q_Play,
  output logic                         Q_Lose,
  output logic [SCORE_W-1:0]           Score,
  output logic [SCORE_W-1:0]           High_Score,
  output logic                         Score_Pulse,
  output logic [2:0]                   Hit_Pipe
);

  localparam int SUM_W = SCORE_W + 4;
  localparam logic [COORD_W-1:0] CEIL_C  = COORD_W'(CEIL_Y);
  localparam logic [COORD_W-1:0] FLOOR_C = COORD_W'(FLOOR_Y);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  state_t             state_reg, state_next;
  logic [SCORE_W-1:0] score_reg, score_next;
  logic [SCORE_W-1:0] high_reg, high_next;
  logic [2:0]         hit_reg, hit_next;
  logic               pulse_reg, pulse_next;

  logic [NUM_PIPES-1:0] collide;
  logic [NUM_PIPES-1:0] newpass;
  logic                 update;
  logic                 clear;
  logic                 boundary;
  logic                 any_collide;
  logic [2:0]           hit_idx;
  logic [3:0]           pass_cnt;
  logic [SUM_W-1:0]     score_sum;
  logic [SCORE_W-1:0]   score_sat;

  for (genvar gi = 0; gi < NUM_PIPES; gi++) begin : g_chan
    pipe_channel_check #(
      .COORD_W(COORD_W)
    ) u_chk (
      .Clk       (Clk),
      .reset     (reset),
      .update    (update),
      .clear     (clear),
      .pipe_valid(Pipe_Valid[gi]),
      .bird_x_l  (Bird_X_L),
      .bird_x_r  (Bird_X_R),
      .bird_y_t  (Bird_Y_T),
      .bird_y_b  (Bird_Y_B),
      .pipe_x_l  (Pipe_X_L[gi*COORD_W +: COORD_W]),
      .pipe_x_r  (Pipe_X_R[gi*COORD_W +: COORD_W]),
      .gap_y_t   (Gap_Y_T[gi*COORD_W +: COORD_W]),
      .gap_y_b   (Gap_Y_B[gi*COORD_W +: COORD_W]),
      .collide_i (collide[gi]),
      .newpass_i (newpass[gi])
    );
  end

  assign boundary    = (Bird_Y_T <= CEIL_C) || (Bird_Y_B >= FLOOR_C);
  assign any_collide = (|collide) || boundary;

  // Lowest colliding channel wins; boundary code only when no pipe was hit.
  always_comb begin
    hit_idx = HIT_BOUNDARY;
    for (int i = NUM_PIPES - 1; i >= 0; i--) begin
      if (collide[i]) hit_idx = 3'(i);
    end
  end

  always_comb begin
    pass_cnt = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      pass_cnt = pass_cnt + 4'(newpass[i]);
    end
  end

  assign score_sum = SUM_W'(score_reg) + SUM_W'(pass_cnt);
  assign score_sat = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];

  always_comb begin
    state_next = state_reg;
    score_next = score_reg;
    high_next  = high_reg;
    hit_next   = hit_reg;
    pulse_next = 1'b0;
    update     = 1'b0;
    clear      = 1'b0;
    case (state_reg)
      ST_INITIAL: begin
        if (Start) begin
          state_next = ST_PLAY;
          score_next = '0;
          clear      = 1'b1;
        end
      end
      ST_PLAY: begin
        if (Frame_Tick) begin
          if (any_collide) begin
            state_next = ST_LOSE;
            hit_next   = hit_idx;
            high_next  = (score_reg > high_reg) ? score_reg : high_reg;
          end else begin
            update = 1'b1;
            if (pass_cnt != 4'd0) begin
              score_next = score_sat;
              pulse_next = 1'b1;
            end
          end
        end
      end
      ST_LOSE: begin
        if (Ack) state_next = ST_INITIAL;
      end
      default: state_next = ST_INITIAL;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_INITIAL;
      score_reg <= '0;
      high_reg  <= '0;
      hit_reg   <= 3'd0;
      pulse_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      score_reg <= score_next;
      high_reg  <= high_next;
      hit_reg   <= hit_next;
      pulse_reg <= pulse_next;
    end
  end

  assign Q_Initial   = (state_reg == ST_INITIAL);
  assign Q_Play      = (state_reg == ST_PLAY);
  assign Q_Lose      = (state_reg == ST_LOSE);
  assign Score       = score_reg;
  assign High_Score  = high_reg;
  assign Score_Pulse = pulse_reg;
  assign Hit_Pipe    = hit_reg;

endmodule

// File: tb/tb_pipe_collision_scorer.sv
// Directed bench: expectations are queued as each step is driven and
// popped against the DUT outputs one cycle later.
module tb_pipe_collision_scorer;

  localparam int NP = 4;
  localparam int CW = 10;
  localparam int SW = 8;

  logic          Clk = 1'b0;
  logic          reset = 1'b1;
  logic          Start = 1'b0;
  logic          Ack = 1'b0;
  logic          Frame_Tick = 1'b0;
  logic [CW-1:0] Bird_X_L = '0, Bird_X_R = '0, Bird_Y_T = '0, Bird_Y_B = '0;
  logic [NP-1:0] Pipe_Valid = '0;
  logic [NP*CW-1:0] Pipe_X_L = '0, Pipe_X_R = '0, Gap_Y_T = '0, Gap_Y_B = '0;
  logic          Q_Initial, Q_Play, Q_Lose, Score_Pulse;
  logic [SW-1:0] Score, High_Score;
  logic [2:0]    Hit_Pipe;

  int checks = 0;
  int errors = 0;
  int exp_score;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  pipe_collision_scorer #(
    .NUM_PIPES(NP), .COORD_W(CW), .SCORE_W(SW), .CEIL_Y(0), .FLOOR_Y(470)
  ) dut (
    .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack), .Frame_Tick(Frame_Tick),
    .Bird_X_L(Bird_X_L), .Bird_X_R(Bird_X_R), .Bird_Y_T(Bird_Y_T), .Bird_Y_B(Bird_Y_B),
    .Pipe_Valid(Pipe_Valid), .Pipe_X_L(Pipe_X_L), .Pipe_X_R(Pipe_X_R),
    .Gap_Y_T(Gap_Y_T), .Gap_Y_B(Gap_Y_B),
    .Q_Initial(Q_Initial), .Q_Play(Q_Play), .Q_Lose(Q_Lose),
    .Score(Score), .High_Score(High_Score), .Score_Pulse(Score_Pulse), .Hit_Pipe(Hit_Pipe)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] observe(string tag);
    case (tag)
      "q_initial": return 32'(Q_Initial);
      "q_play":    return 32'(Q_Play);
      "q_lose":    return 32'(Q_Lose);
      "score":     return 32'(Score);
      "high":      return 32'(High_Score);
      "pulse":     return 32'(Score_Pulse);
      "hit":       return 32'(Hit_Pipe);
      default:     return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(string tag, logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain(string step);
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.tag);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s/%s observed=%0d expected=%0d", step, e.tag, obs, e.exp);
      end
    end
    $display("step %-12s score=%0d high=%0d pulse=%0b state=%b%b%b hit=%0d",
             step, Score, High_Score, Score_Pulse, Q_Lose, Q_Play, Q_Initial, Hit_Pipe);
  endtask

  task automatic clk_step(input logic tick);
    Frame_Tick = tick;
    @(posedge Clk);
    #1;
    Frame_Tick = 1'b0;
  endtask

  task automatic push_state(input int st);
    push("q_initial", 32'(st == 0));
    push("q_play",    32'(st == 1));
    push("q_lose",    32'(st == 2));
  endtask

  // Bit set: pipe sits behind the bird (X 60..99); clear: ahead (X 300..340).
  task automatic set_pipes(input logic [NP-1:0] behind);
    for (int i = 0; i < NP; i++) begin
      Pipe_X_L[i*CW +: CW] = behind[i] ? CW'(60) : CW'(300);
      Pipe_X_R[i*CW +: CW] = behind[i] ? CW'(99) : CW'(340);
      Gap_Y_T[i*CW +: CW]  = CW'(150);
      Gap_Y_B[i*CW +: CW]  = CW'(250);
    end
  endtask

  initial begin
    #12;
    push_state(0); push("score", 0); push("high", 0); push("pulse", 0); push("hit", 0);
    drain("reset");
    reset = 1'b0;
    @(posedge Clk); #1;

    Start = 1'b1; push_state(1); push("score", 0);
    clk_step(1'b0); Start = 1'b0; drain("start");

    Pipe_Valid = 4'b0001;
    Pipe_X_L[0 +: CW] = 200; Pipe_X_R[0 +: CW] = 240; Gap_Y_T[0 +: CW] = 150; Gap_Y_B[0 +: CW] = 250;
    Bird_X_L = 210; Bird_X_R = 220; Bird_Y_T = 160; Bird_Y_B = 170;
    push_state(1);
    clk_step(1'b1); drain("in_gap");

    Bird_Y_T = 140;
    push_state(2); push("hit", 0); push("high", 0);
    clk_step(1'b1); drain("pipe_hit");

    Start = 1'b1; push_state(2);
    clk_step(1'b0); Start = 1'b0; drain("start_in_lose");
    Ack = 1'b1; push_state(0); push("high", 0);
    clk_step(1'b0); Ack = 1'b0; drain("ack");
    Start = 1'b1; push_state(1); push("score", 0);
    clk_step(1'b0); Start = 1'b0; drain("restart");

    // Single pipe (channel 1) crossing the bird's left edge.
    Bird_X_L = 100; Bird_X_R = 110; Bird_Y_T = 200; Bird_Y_B = 210;
    set_pipes(4'b0000);
    Pipe_Valid = 4'b0010;
    Pipe_X_L[CW +: CW] = 60; Pipe_X_R[CW +: CW] = 101;
    push("score", 0); push("pulse", 0); push_state(1);
    clk_step(1'b1); drain("p1_at_101");
    Pipe_X_R[CW +: CW] = 99;
    push("score", 1); push("pulse", 1);
    clk_step(1'b1); drain("p1_at_99");
    push("score", 1); push("pulse", 0);
    clk_step(1'b0); drain("no_tick");
    push("score", 1); push("pulse", 0);
    clk_step(1'b1); drain("p1_hold_99");
    Pipe_Valid = 4'b0000;
    push("score", 1);
    clk_step(1'b1); drain("p1_invalid");
    Pipe_Valid = 4'b0010;
    Pipe_X_L[CW +: CW] = 300; Pipe_X_R[CW +: CW] = 340;
    push("score", 1); push("pulse", 0);
    clk_step(1'b1); drain("p1_recycled");
    Pipe_X_L[CW +: CW] = 60; Pipe_X_R[CW +: CW] = 99;
    push("score", 2); push("pulse", 1);
    clk_step(1'b1); drain("p1_pass2");

    Pipe_Valid = 4'b0111;
    set_pipes(4'b0111);
    push("score", 4); push("pulse", 1);
    clk_step(1'b1); drain("p0p2_pass");
    push("pulse", 0);
    clk_step(1'b0); drain("pulse_drop");

    // Floor hit on the same tick pipe 3 would pass: collision wins.
    Pipe_Valid = 4'b1111;
    set_pipes(4'b1111);
    Bird_Y_B = 470;
    push_state(2); push("hit", 7); push("score", 4); push("high", 4); push("pulse", 0);
    clk_step(1'b1); drain("floor_hit");
    Ack = 1'b1; push_state(0); push("high", 4); push("score", 4);
    clk_step(1'b0); Ack = 1'b0; drain("ack2");
    Start = 1'b1; push_state(1); push("score", 0); push("high", 4);
    clk_step(1'b0); Start = 1'b0; drain("restart2");

    // Saturation run up to 254, then a double pass that clips at 255.
    Bird_Y_B = 210;
    exp_score = 0;
    for (int r = 0; r < 63; r++) begin
      set_pipes(4'b1111);
      exp_score += 4;
      push("score", 32'(exp_score)); push("pulse", 1);
      clk_step(1'b1); drain("sat_round");
      set_pipes(4'b0000);
      clk_step(1'b1);
    end
    set_pipes(4'b0011);
    push("score", 254);
    clk_step(1'b1); drain("to_254");
    set_pipes(4'b0000);
    clk_step(1'b1);
    set_pipes(4'b0101);
    push("score", 255); push("pulse", 1); push("high", 4);
    clk_step(1'b1); drain("saturate");

    Bird_Y_B = 470;
    push_state(2); push("hit", 7); push("high", 255);
    clk_step(1'b1); drain("floor_hit2");
    Bird_Y_B = 210;
    Ack = 1'b1; clk_step(1'b0); Ack = 1'b0;
    Start = 1'b1; push("score", 0); push_state(1);
    clk_step(1'b0); Start = 1'b0; drain("restart3");
    set_pipes(4'b1111); clk_step(1'b1);
    set_pipes(4'b0000); clk_step(1'b1);
    set_pipes(4'b0001);
    push("score", 5); push_state(1);
    clk_step(1'b1); drain("score5");

    // Asynchronous reset between clock edges.
    #2 reset = 1'b1;
    #1;
    push_state(0); push("score", 0); push("high", 0); push("pulse", 0); push("hit", 0);
    drain("async_reset");
    @(negedge Clk);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
